// File: rtl/fuzzy_pkg.sv
// Shared types and constants for the fuzzy-controller back end.
// Rule index i maps to w/g entries row-major: 0 = w00 ... 4 = w11 ... 8 = w22.
package fuzzy_pkg;

    localparam int Q15_MAX       = 32767;
    localparam int PCT_MAX       = 100;
    localparam int N_RULES       = 9;
    localparam int CFG_ADDR_MODE = 9;
    localparam int DIV_STEPS     = 16;

    typedef logic [15:0] q15_t;
    typedef logic [7:0]  pct_t;
    typedef q15_t [N_RULES-1:0] wvec_t;
    typedef pct_t [N_RULES-1:0] gvec_t;

    typedef enum logic [1:0] {
        IDLE,
        CAPT,
        DIV,
        DONE
    } seq_state_t;

    function automatic pct_t sat_pct(input logic [7:0] v);
        return (v > 8'(PCT_MAX)) ? 8'(PCT_MAX) : v;
    endfunction

endpackage

// File: rtl/divu_q15.sv
// Bit-serial restoring divider: 31-bit dividend / 16-bit divisor, one quotient bit per cycle.
// The quotient output is valid in the cycle that done is high; the caller samples it on that edge.
module divu_q15
    import fuzzy_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [30:0] dividend,
    input  logic [15:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [15:0] quotient
);

    logic [15:0] rem_q, rem_d;
    logic [15:0] lq_q, lq_d;
    logic [15:0] dvs_q, dvs_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic [16:0] trial;
    logic        qbit;

    always_comb begin
        // NOTE: every signal written here gets a default first; a path that leaves one unassigned infers a latch.
        rem_d  = rem_q;
        lq_d   = lq_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done   = 1'b0;
        // lq holds unconsumed dividend bits on top and shifts quotient bits in at the bottom.
        trial  = {rem_q, lq_q[15]};
        qbit   = (trial >= {1'b0, dvs_q});
        if (start) begin
            rem_d  = {1'b0, dividend[30:16]};
            lq_d   = dividend[15:0];
            dvs_d  = divisor;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            rem_d = qbit ? 16'(trial - {1'b0, dvs_q}) : trial[15:0];
            lq_d  = {lq_q[14:0], qbit};
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'(DIV_STEPS - 1)) begin
                busy_d = 1'b0;
                done   = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            lq_q   <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            lq_q   <= lq_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy     = busy_q;
    assign quotient = lq_d;

endmodule

// File: rtl/fuzzy_defuzz_seq.sv
// Defuzzifier sequencer: accepts a weight vector, drives the external sum stage,
// divides S_wg/S_w into a Q1.15 centroid and returns it over a valid/ready handshake.
module fuzzy_defuzz_seq
    import fuzzy_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cfg_we,
    input  logic [3:0] cfg_addr,
    input  logic [7:0] cfg_wdata,
    output logic       cfg_busy,
    input  logic       in_valid,
    output logic       in_ready,
    input  wvec_t      in_w,
    output logic       agg_mode,
    output wvec_t      agg_w,
    output gvec_t      agg_g,
    input  q15_t       agg_sw,
    input  q15_t       agg_swg,
    output logic       out_valid,
    input  logic       out_ready,
    output q15_t       out_y,
    output logic       out_div0
);

    seq_state_t state_q, state_d;
    wvec_t      agg_w_q, agg_w_d;
    gvec_t      g_q, g_d;
    logic       mode_q, mode_d;
    q15_t       out_y_q, out_y_d;
    logic       div0_q, div0_d;
    logic       out_valid_q, out_valid_d;
    logic       in_ready_q, in_ready_d;
    logic       cfg_busy_q, cfg_busy_d;
    logic       sat_q, sat_d;
    logic       div_start, div_busy, div_done;
    q15_t       div_quot;

    divu_q15 u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend ({agg_swg, 15'd0}),
        .divisor  (agg_sw),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quot)
    );

    always_comb begin
        state_d     = state_q;
        agg_w_d     = agg_w_q;
        g_d         = g_q;
        mode_d      = mode_q;
        out_y_d     = out_y_q;
        div0_d      = div0_q;
        out_valid_d = out_valid_q;
        sat_d       = sat_q;
        div_start   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_we) begin
                    for (int i = 0; i < N_RULES; i++) begin
                        if (cfg_addr == 4'(i)) g_d[i] = sat_pct(cfg_wdata);
                    end
                    if (cfg_addr == 4'(CFG_ADDR_MODE)) mode_d = cfg_wdata[0];
                end
                if (in_valid) begin
                    agg_w_d = in_w;
                    state_d = CAPT;
                end
            end
            CAPT: begin
                if (agg_sw == '0) begin
                    out_y_d     = '0;
                    div0_d      = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    div_start = 1'b1;
                    // S_wg >= S_w means q >= 32768, which may also exceed the 16-bit quotient.
                    sat_d     = (agg_swg >= agg_sw);
                    state_d   = DIV;
                end
            end
            DIV: begin
                if (div_done) begin
                    out_y_d     = (sat_q || div_quot[15]) ? q15_t'(Q15_MAX) : div_quot;
                    div0_d      = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else if (!div_busy) begin
                    state_d = IDLE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d = (state_d == IDLE);
        cfg_busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the consequent table is a small flop array, not a RAM, so reset can and does clear it.
            state_q     <= IDLE;
            agg_w_q     <= '0;
            g_q         <= '0;
            mode_q      <= 1'b0;
            out_y_q     <= '0;
            div0_q      <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            cfg_busy_q  <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            agg_w_q     <= agg_w_d;
            g_q         <= g_d;
            mode_q      <= mode_d;
            out_y_q     <= out_y_d;
            div0_q      <= div0_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            cfg_busy_q  <= cfg_busy_d;
            sat_q       <= sat_d;
        end
    end

    assign agg_w     = agg_w_q;
    assign agg_g     = g_q;
    assign agg_mode  = mode_q;
    assign out_y     = out_y_q;
    assign out_div0  = div0_q;
    assign out_valid = out_valid_q;
    assign in_ready  = in_ready_q;
    assign cfg_busy  = cfg_busy_q;

endmodule

// File: tb/tb_fuzzy_defuzz_seq.sv
// Scoreboard bench for fuzzy_defuzz_seq with a behavioural sum-stage stand-in and reference model.
module tb_fuzzy_defuzz_seq;
    import fuzzy_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_we = 1'b0;
    logic [3:0] cfg_addr = '0;
    logic [7:0] cfg_wdata = '0;
    logic       cfg_busy;
    logic       in_valid = 1'b0;
    logic       in_ready;
    wvec_t      in_w = '0;
    logic       agg_mode;
    wvec_t      agg_w;
    gvec_t      agg_g;
    q15_t       agg_sw, agg_swg;
    logic       out_valid;
    logic       out_ready = 1'b0;
    q15_t       out_y;
    logic       out_div0;

    always #5 clk = ~clk;

    fuzzy_defuzz_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_busy  (cfg_busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_w      (in_w),
        .agg_mode  (agg_mode),
        .agg_w     (agg_w),
        .agg_g     (agg_g),
        .agg_sw    (agg_sw),
        .agg_swg   (agg_swg),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_div0  (out_div0)
    );

    // Sum stage stand-in: mode 0 leaves the centre rule out; both sums saturate at Q15_MAX.
    function automatic int sum_w(input wvec_t w, input logic mode);
        int s = 0;
        for (int i = 0; i < N_RULES; i++) if (mode || i != 4) s += int'(w[i]);
        return (s > Q15_MAX) ? Q15_MAX : s;
    endfunction

    function automatic int sum_wg(input wvec_t w, input gvec_t g, input logic mode);
        int s = 0;
        for (int i = 0; i < N_RULES; i++) if (mode || i != 4) s += (int'(w[i]) * int'(g[i])) / 100;
        return (s > Q15_MAX) ? Q15_MAX : s;
    endfunction

    assign agg_sw  = q15_t'(sum_w(agg_w, agg_mode));
    assign agg_swg = q15_t'(sum_wg(agg_w, agg_g, agg_mode));

    typedef struct {
        int y;
        bit div0;
        int lat;
        int acc;
    } exp_t;

    exp_t  sb[$];
    exp_t  mon_e;
    gvec_t g_m = '0;
    logic  mode_m = 1'b0;
    int    n_vec = 0;
    int    n_miss = 0;
    int    cyc = 0;
    logic  hold_ready = 1'b0;
    logic  prev_valid = 1'b0;
    logic  prev_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint got, input longint exp);
        n_vec++;
        if (got != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic void apply_cfg(input logic [3:0] a, input logic [7:0] d);
        if (int'(a) < N_RULES) g_m[int'(a)] = (d > 8'd100) ? 8'd100 : d;
        else if (int'(a) == CFG_ADDR_MODE) mode_m = d[0];
    endfunction

    task automatic cfg_write(input logic [3:0] a, input logic [7:0] d, input bit taken);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(negedge clk);
        cfg_we = 1'b0;
        if (taken) apply_cfg(a, d);
    endtask

    task automatic send(input wvec_t w, input bit cfg_en, input logic [3:0] a, input logic [7:0] d);
        int   n = 0;
        int   sw, swg;
        exp_t e;
        @(negedge clk);
        in_w = w; in_valid = 1'b1;
        cfg_we = cfg_en; cfg_addr = a; cfg_wdata = d;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        if (!in_ready) begin
            check("accept_timeout", 0, 1);
            in_valid = 1'b0; cfg_we = 1'b0;
            return;
        end
        if (cfg_en) apply_cfg(a, d);
        sw  = sum_w(w, mode_m);
        swg = sum_wg(w, g_m, mode_m);
        e.div0 = (sw == 0);
        e.y    = (sw == 0) ? 0 : int'(((longint'(swg) * 32768) / sw > Q15_MAX) ? Q15_MAX : (longint'(swg) * 32768) / sw);
        e.lat  = (sw == 0) ? 1 : 17;
        e.acc  = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0; cfg_we = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || !in_ready) && n < 200) begin @(negedge clk); n++; end
        check("idle_timeout", (sb.size() == 0 && in_ready) ? 1 : 0, 1);
    endtask

    // Output handshake driver, kept off the sampling edge.
    initial forever begin
        @(posedge clk);
        #1;
        out_ready = hold_ready ? 1'b0 : ($urandom_range(3) != 0);
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid <= 1'b0;
        end else begin
            if (prev_valid && !prev_ready) check("valid_held", out_valid, 1);
            if (out_valid && !prev_valid) begin
                if (sb.size() == 0) check("spurious_result", 1, 0);
                else check("latency", cyc - sb[0].acc, sb[0].lat);
            end
            if (out_valid && sb.size() != 0) begin
                if (out_ready) begin
                    mon_e = sb.pop_front();
                    check("out_y", out_y, mon_e.y);
                    check("out_div0", out_div0, mon_e.div0);
                end else begin
                    check("held_y", out_y, sb[0].y);
                    check("held_div0", out_div0, sb[0].div0);
                end
            end
            prev_valid <= out_valid;
            prev_ready <= out_ready;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        wvec_t w;
        int    n;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_cfg_busy", cfg_busy, 0);
        check("rst_agg_mode", agg_mode, 0);
        check("rst_agg_w", |agg_w, 0);
        check("rst_agg_g", |agg_g, 0);
        check("rst_out_y", out_y, 0);
        check("rst_out_div0", out_div0, 0);

        // Clamp at the top: q = 32768 -> 32767.
        cfg_write(4'd0, 8'd100, 1);
        w = '0; w[0] = 16'd16384;
        send(w, 0, 0, 0);
        wait_idle();

        // Saturated S_w.
        cfg_write(4'd0, 8'd0, 1);
        cfg_write(4'd8, 8'd100, 1);
        w = '0; w[0] = 16'd16384; w[8] = 16'd16384;
        send(w, 0, 0, 0);
        wait_idle();

        // Divide by zero.
        send('0, 0, 0, 0);
        wait_idle();

        // Output held in DONE; config writes while busy are dropped.
        cfg_write(4'd0, 8'd100, 1);
        hold_ready = 1'b1;
        w = '0; w[0] = 16'd16384;
        send(w, 0, 0, 0);
        n = 0;
        while (!out_valid && n < 40) begin @(negedge clk); n++; end
        check("hold_valid_seen", out_valid, 1);
        repeat (8) begin
            check("hold_in_ready", in_ready, 0);
            check("hold_cfg_busy", cfg_busy, 1);
            @(negedge clk);
        end
        cfg_write(4'd0, 8'd55, 0);
        hold_ready = 1'b0;
        wait_idle();
        send(w, 0, 0, 0);
        wait_idle();

        // Percent saturation and mode.
        cfg_write(4'd4, 8'd200, 1);
        cfg_write(4'd9, 8'd1, 1);
        w = '0; w[4] = 16'd32767;
        send(w, 0, 0, 0);
        wait_idle();
        cfg_write(4'd9, 8'd0, 1);
        send(w, 0, 0, 0);
        wait_idle();

        // Config and accept on the same edge: the transaction sees the new mode.
        send(w, 1, 4'd9, 8'd1);
        wait_idle();

        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(1) == 1) cfg_write(4'($urandom_range(15)), 8'($urandom_range(255)), 1);
            for (int i = 0; i < N_RULES; i++)
                w[i] = ($urandom_range(1) == 1) ? 16'($urandom_range(32767)) : 16'd0;
            if (t % 8 == 7) w = '0;
            send(w, $urandom_range(3) == 0, 4'($urandom_range(15)), 8'($urandom_range(255)));
            wait_idle();
        end

        // Reset in the middle of the division.
        w = '0; w[1] = 16'd20000; w[2] = 16'd7000;
        send(w, 0, 0, 0);
        repeat (9) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        g_m = '0;
        mode_m = 1'b0;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_agg_w", |agg_w, 0);
        check("midrst_agg_g", |agg_g, 0);
        check("midrst_agg_mode", agg_mode, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", in_ready, 1);
        repeat (20) @(negedge clk);
        check("midrst_no_stale", out_valid, 0);
        w = '0; w[0] = 16'd1000;
        send(w, 0, 0, 0);
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
